fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the multi-cycle control unit.
- Holds the PC and the instruction register (IR), and computes next-PC from PCSrc.
- Runs a req/ack handshake to a wait-state instruction memory.
- Feeds opcode and decoded fields to the control unit. Raises fetch_stall so the top level freezes control-unit state while a fetch is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 15, maximum cycles in F_REQ before a fetch timeout (1..255).
- HALT_WORD, 32'hFC00_0000, IR value injected on timeout (opcode 111111).

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- PCWre  in  1  PC write enable from control unit.
- IRWre  in  1  IR load request from control unit.
- InsMemRW  in  1  instruction-memory read enable; a fetch starts only when this and IRWre are both 1.
- PCSrc  in  2  next-PC select: 00 seq, 01 branch, 10 jr, 11 j/jal.
- ext_imm  in  32  sign/zero-extended immediate, produced by the extender under ExtSel.
- rs_data  in  32  register-file rs read data, used for jr.
- imem_req  out  1  memory read request.
- imem_addr  out  32  memory word address (byte address, low bits 00).
- imem_rdata  in  32  memory read data.
- imem_ack  in  1  read data valid.
- PC  out  32  current PC.
- PC4  out  32  PC+4, used as jal link data.
- IR  out  32  instruction register.
- opcode  out  6  IR[31:26].
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- sa  out  5  IR[10:6].
- imm16  out  16  IR[15:0].
- ir_valid  out  1  IR holds a fetched word since reset.
- fetch_stall  out  1  fetch in progress; freeze control unit.
- fetch_err  out  1  sticky timeout flag.
- addr_err  out  1  one-cycle pulse on a misaligned jr target.

Behaviour:
- Reset (Reset=0, asynchronous): PC=RESET_PC, IR=0, state F_IDLE, wait counter=0, imem_req=0, ir_valid=0, fetch_err=0, addr_err=0. Reset asserted mid-fetch aborts the fetch and drops imem_req immediately.
- Fetch FSM, states F_IDLE and F_REQ:
  - F_IDLE: if IRWre & InsMemRW, go to F_REQ on the next edge; otherwise stay. IRWre=1 with InsMemRW=0 is a no-op and IR holds.
  - F_REQ: imem_req=1 and imem_addr=PC, both held stable until exit. Counter increments each cycle.
  - F_REQ exit on ack: imem_ack=1 sampled at an edge -> IR<=imem_rdata, ir_valid<=1, counter<=0, go to F_IDLE.
  - F_REQ exit on timeout: counter reaches MAX_WAIT with no ack -> IR<=HALT_WORD, fetch_err<=1 (sticky), ir_valid<=1, go to F_IDLE.
  - imem_ack is ignored in F_IDLE.
- fetch_stall = (state==F_REQ) | (state==F_IDLE & IRWre & InsMemRW). It is combinational.
- Latency: when ack arrives in the first F_REQ cycle, IR updates 2 edges after the IRWre request and fetch_stall is high for 2 cycles.
- PC update happens at an edge where PCWre=1 and fetch_stall=0. PCWre while stalled is ignored.
  - 00: PC+4.
  - 01: PC+4+(ext_imm<<2).
  - 10: {rs_data[31:2],2'b00}. If rs_data[1:0]!=0, pulse addr_err for one cycle.
  - 11: {PC4[31:28], IR[25:0], 2'b00}.
- All arithmetic is 32-bit modulo 2^32; PC wraps from FFFF_FFFC to 0000_0000 silently.
- PC4 = PC+4, combinational.
- Field outputs are combinational slices of IR.
- PC holds during F_REQ, so imem_addr is stable for the whole request.

Test Plan:
- Reset, then IRWre=InsMemRW=1 for 1 cycle, ack on the first F_REQ cycle with rdata=32'h0822_0005 -> imem_addr=0; IR=0822_0005, opcode=000010, rs=1, rt=2, imm16=5; fetch_stall high exactly 2 cycles; ir_valid=1.
- Memory delays ack 4 cycles -> imem_req and imem_addr held constant for 5 cycles, PCWre pulses during the stall are ignored, IR is loaded on the ack edge.
- No ack with MAX_WAIT=15 -> after 15 cycles in F_REQ, IR=FC00_0000, fetch_err=1 and stays 1 through later successful fetches until reset.
- PC=0000_0010 with PCWre=1: PCSrc=01, ext_imm=FFFF_FFFE -> PC=0000_000C; PCSrc=11, IR[25:0]=26'h10 -> PC=0000_0040; PCSrc=10, rs_data=0000_0103 -> PC=0000_0100 and addr_err pulses for 1 cycle.
- PC=FFFF_FFFC, PCSrc=00, PCWre=1 -> PC=0000_0000.
- Reset driven low 2 cycles into a 4-cycle wait -> imem_req=0 immediately, PC=RESET_PC, IR=0, ir_valid=0; a late ack after release is ignored in F_IDLE.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC, IR, next-PC selection and a
// req/ack fetch handshake towards a wait-state instruction memory.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_WAIT  = 15,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic        IRWre,
    input  logic        InsMemRW,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ext_imm,
    input  logic [31:0] rs_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic [31:0] IR,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [15:0] imm16,
    output logic        ir_valid,
    output logic        fetch_stall,
    output logic        fetch_err,
    output logic        addr_err
);

    typedef enum logic {
        F_IDLE,
        F_REQ
    } state_t;

    // Timeout fires on the edge that ends the MAX_WAIT-th request cycle.
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_nxt;
    logic        ir_load;
    logic [31:0] ir_nxt;
    logic        timeout;
    logic        fetch_go;
    logic        pc_en;
    logic [31:0] pc_nxt;
    logic        misalign;

    assign fetch_go    = IRWre & InsMemRW;
    assign fetch_stall = (state == F_REQ) | ((state == F_IDLE) & fetch_go);
    assign imem_req    = (state == F_REQ);
    assign imem_addr   = PC;
    assign PC4         = PC + 32'd4;

    assign opcode = IR[31:26];
    assign rs     = IR[25:21];
    assign rt     = IR[20:16];
    assign rd     = IR[15:11];
    assign sa     = IR[10:6];
    assign imm16  = IR[15:0];

    // Fetch FSM next state, wait counter and IR load selection.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        ir_load      = 1'b0;
        ir_nxt       = IR;
        timeout      = 1'b0;
        unique case (state)
            F_IDLE: begin
                wait_cnt_nxt = 8'd0;
                if (fetch_go) begin
                    state_nxt = F_REQ;
                end
            end
            F_REQ: begin
                if (imem_ack) begin
                    ir_load      = 1'b1;
                    ir_nxt       = imem_rdata;
                    state_nxt    = F_IDLE;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == LAST_WAIT) begin
                    ir_load      = 1'b1;
                    ir_nxt       = HALT_WORD;
                    timeout      = 1'b1;
                    state_nxt    = F_IDLE;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
        endcase
    end

    // Fetch FSM state and wait counter registers.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= F_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // IR, valid flag and sticky timeout flag.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            IR        <= 32'd0;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            if (ir_load) begin
                IR       <= ir_nxt;
                ir_valid <= 1'b1;
            end
            if (timeout) begin
                fetch_err <= 1'b1;
            end
        end
    end

    // Next-PC mux; the PC is frozen while a fetch is outstanding.
    always_comb begin
        pc_en    = PCWre & ~fetch_stall;
        pc_nxt   = PC4;
        misalign = 1'b0;
        unique case (PCSrc)
            2'b00: pc_nxt = PC4;
            2'b01: pc_nxt = PC4 + (ext_imm << 2);
            2'b10: begin
                pc_nxt   = {rs_data[31:2], 2'b00};
                misalign = pc_en & (rs_data[1:0] != 2'b00);
            end
            2'b11: pc_nxt = {PC4[31:28], IR[25:0], 2'b00};
        endcase
    end

    // PC register and one-cycle misaligned jr target pulse.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            PC       <= RESET_PC;
            addr_err <= 1'b0;
        end else begin
            addr_err <= misalign;
            if (pc_en) begin
                PC <= pc_nxt;
            end
        end
    end

endmodule
